dl_trans: RTL and testbench

//  Downlink counterpart of the uplink lane splitter. Merges two 32-bit frequency-domain

---
 rtl/dl_trans_pkg.sv | 18 +
 rtl/dl_trans_if.sv | 47 ++++
 rtl/dl_trans_pp_buf.sv | 48 ++++
 rtl/dl_trans.sv | 110 +++++++++++
 tb/tb_dl_trans.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dl_trans_pkg.sv
// Shared constants and types for the DL/UL lane translators.
// Slot geometry, phase width, state encoding and frame-pulse delay.
package dl_ul_trans_pkg;

  localparam int SLOT_LEN  = 8;
  localparam int HALF_SLOT = 4;
  localparam int PH_W      = 3;
  localparam int FFRAM_DLY = 9;

  typedef logic [PH_W-1:0] ph_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_e;

endpackage

// File: rtl/dl_trans_if.sv
// Lane-in / TDM-out signal bundle for dl_trans.
// o_err_cnt and ERR_CNT_W exist only with DL_TRANS_ERR_CNT_EN.
interface dl_trans_if #(
  parameter int DATA_W = 32
`ifdef DL_TRANS_ERR_CNT_EN
  , parameter int ERR_CNT_W = 16
`endif
);

  logic              i_freq_ffram;
  logic [DATA_W-1:0] i_freq0_fdata;
  logic [DATA_W-1:0] i_freq1_fdata;
  logic              o_freq_ffram;
  logic [DATA_W-1:0] o_freq_fdata;
  logic              o_freq_valid;
  logic              o_align_err;
`ifdef DL_TRANS_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] o_err_cnt;
`endif

  modport master (
    output i_freq_ffram,
    output i_freq0_fdata,
    output i_freq1_fdata,
    input  o_freq_ffram,
    input  o_freq_fdata,
    input  o_freq_valid,
    input  o_align_err
`ifdef DL_TRANS_ERR_CNT_EN
    , input o_err_cnt
`endif
  );

  modport slave (
    input  i_freq_ffram,
    input  i_freq0_fdata,
    input  i_freq1_fdata,
    output o_freq_ffram,
    output o_freq_fdata,
    output o_freq_valid,
    output o_align_err
`ifdef DL_TRANS_ERR_CNT_EN
    , output o_err_cnt
`endif
  );

endinterface

// File: rtl/dl_trans_pp_buf.sv
// Ping-pong slot buffer: 2 banks of 8 words, 2 write ports, 1 read.
// Write bank flips after phase 7; the read bank is always the other one.
module dl_trans_pp_buf
  import dl_ul_trans_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  ph_t               wr_ph_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  ph_t               rd_ph_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic              wb_q;
  logic              wb_d;
  logic              rb;
  ph_t               lo_ph;
  logic [DATA_W-1:0] mem_q [2][SLOT_LEN];

  assign rb    = ~wb_q;
  assign lo_ph = wr_ph_i - ph_t'(HALF_SLOT);

  always_comb begin
    wb_d = wb_q;
    if (wr_en_i && wr_ph_i == ph_t'(SLOT_LEN-1))
      wb_d = ~wb_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wb_q <= 1'b0;
    else       wb_q <= wb_d;
  end

  // lane 0 fills words 0..3, lane 1 fills words 4..7
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wb_q][lo_ph]   <= wr0_data_i;
      mem_q[wb_q][wr_ph_i] <= wr1_data_i;
    end
  end

  assign rd_data_o = mem_q[rb][rd_ph_i];

endmodule

// File: rtl/dl_trans.sv
// DL lane merger: two half-slot lanes -> one 8-word TDM stream.
// Optional saturating align-error counter: DL_TRANS_ERR_CNT_EN.
module dl_trans
  import dl_ul_trans_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef DL_TRANS_ERR_CNT_EN
  , parameter int ERR_CNT_W = 16
`endif
) (
  input  logic     clk_491,
  input  logic     rst_491,
  dl_trans_if.slave bus
);

  state_e                 state_q;
  state_e                 state_d;
  ph_t                    ph_q;
  ph_t                    ph_d;
  logic [FFRAM_DLY-1:0]   sr_q;
  logic [FFRAM_DLY-1:0]   sr_d;
  logic [DATA_W-1:0]      dat_q;
  logic [DATA_W-1:0]      dat_d;
  logic                   vld_q;
  logic                   vld_d;
  logic                   err_q;
  logic                   misalign;
  logic                   wr_en;
  logic [DATA_W-1:0]      rd_data;

  always_comb begin
    ph_d     = bus.i_freq_ffram ? '0 : ph_q + 1'b1;
    misalign = bus.i_freq_ffram
            && ph_q != ph_t'(SLOT_LEN-1)
            && state_q != S_IDLE;
    wr_en    = ph_d[PH_W-1] && state_q != S_IDLE;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.i_freq_ffram) state_d = S_FILL;
      S_FILL: if (!misalign && ph_d == ph_t'(SLOT_LEN-1))
                state_d = S_RUN;
      S_RUN:  if (misalign) state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // a misaligned pulse drops pending delays but keeps itself
  always_comb begin
    sr_d = {sr_q[FFRAM_DLY-2:0], bus.i_freq_ffram};
    if (misalign) begin
      sr_d    = '0;
      sr_d[0] = 1'b1;
    end
    vld_d = state_q == S_RUN && !misalign;
    dat_d = vld_d ? rd_data : '0;
  end

  always_ff @(posedge clk_491 or posedge rst_491) begin
    if (rst_491) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      sr_q    <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      err_q   <= misalign;
    end
  end

  dl_trans_pp_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk_i      (clk_491),
    .rst_i      (rst_491),
    .wr_en_i    (wr_en),
    .wr_ph_i    (ph_d),
    .wr0_data_i (bus.i_freq0_fdata),
    .wr1_data_i (bus.i_freq1_fdata),
    .rd_ph_i    (ph_d),
    .rd_data_o  (rd_data)
  );

  assign bus.o_freq_ffram = sr_q[FFRAM_DLY-1];
  assign bus.o_freq_fdata = dat_q;
  assign bus.o_freq_valid = vld_q;
  assign bus.o_align_err  = err_q;

`ifdef DL_TRANS_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_491 or posedge rst_491) begin
    if (rst_491)
      cnt_q <= '0;
    else if (misalign && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.o_err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dl_trans.sv
// Scoreboard bench for dl_trans; DL_TRANS_ERR_CNT_EN adds
// saturation checks of o_err_cnt with a 2-bit counter.
module tb_dl_trans;

  localparam int DW = 32;
`ifdef DL_TRANS_ERR_CNT_EN
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
`else
  localparam int MAXC = 65535;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

`ifdef DL_TRANS_ERR_CNT_EN
  dl_trans_if #(.DATA_W(DW), .ERR_CNT_W(CW)) bus ();
  dl_trans #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk_491 (clk),
    .rst_491 (rst),
    .bus     (bus)
  );
`else
  dl_trans_if #(.DATA_W(DW)) bus ();
  dl_trans #(.DATA_W(DW)) dut (
    .clk_491 (clk),
    .rst_491 (rst),
    .bus     (bus)
  );
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    logic        ff;
  } exp_t;

  typedef struct {
    int cyc;
    int cnt;
  } err_t;

  exp_t oq[$];
  err_t eq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    err_t r;
    checks++;
    if (bus.o_freq_valid) begin
      if (oq.size() == 0) begin
        errors++;
        $display("FAIL out_unexp cyc=%0d got=%h want=none",
                 cyc, bus.o_freq_fdata);
      end else begin
        e = oq.pop_front();
        if (e.cyc != cyc || e.d != bus.o_freq_fdata
            || e.ff != bus.o_freq_ffram) begin
          errors++;
          $display("FAIL out_word cyc=%0d got=%h ff=%0b want cyc=%0d %h ff=%0b",
                   cyc, bus.o_freq_fdata, bus.o_freq_ffram,
                   e.cyc, e.d, e.ff);
        end
      end
    end else if (bus.o_freq_fdata != '0 || bus.o_freq_ffram) begin
      errors++;
      $display("FAIL out_idle cyc=%0d got=%h ff=%0b want=0",
               cyc, bus.o_freq_fdata, bus.o_freq_ffram);
    end
    if (bus.o_align_err) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL err_unexp cyc=%0d got=1 want=0", cyc);
      end else begin
        r = eq.pop_front();
        if (r.cyc != cyc) begin
          errors++;
          $display("FAIL err_time got=%0d want=%0d", cyc, r.cyc);
        end
`ifdef DL_TRANS_ERR_CNT_EN
        if (int'(bus.o_err_cnt) != r.cnt) begin
          errors++;
          $display("FAIL err_cnt cyc=%0d got=%0d want=%0d",
                   cyc, bus.o_err_cnt, r.cnt);
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_from(input int c);
    while (oq.size() > 0 && oq[$].cyc >= c)
      oq.delete(oq.size() - 1);
    while (eq.size() > 0 && eq[$].cyc >= c)
      eq.delete(eq.size() - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_freq_ffram = 1'b0;
    drop_from(cyc);
    exp_cnt = 0;
    #1;
    checks++;
    if (bus.o_freq_valid || bus.o_freq_fdata != '0
        || bus.o_freq_ffram || bus.o_align_err) begin
      errors++;
      $display("FAIL reset_out got v=%0b d=%h f=%0b e=%0b want=0",
               bus.o_freq_valid, bus.o_freq_fdata,
               bus.o_freq_ffram, bus.o_align_err);
    end
`ifdef DL_TRANS_ERR_CNT_EN
    checks++;
    if (bus.o_err_cnt != '0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d want=0", bus.o_err_cnt);
    end
`endif
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_freq_ffram  = 1'b0;
      bus.i_freq0_fdata = $urandom;
      bus.i_freq1_fdata = $urandom;
      step();
    end
  endtask

  // the next cycle carries a misaligned pulse
  task automatic mark_misalign();
    drop_from(cyc + 1);
    if (exp_cnt < MAXC) exp_cnt++;
    eq.push_back('{cyc + 1, exp_cnt});
  endtask

  task automatic slot(input bit ff, input int len,
                      input logic [DW-1:0] base, input bit ex);
    for (int i = 0; i < len; i++) begin
      bus.i_freq_ffram = ff && i == 0;
      if (i >= 4) begin
        bus.i_freq0_fdata = base + DW'(i - 4);
        bus.i_freq1_fdata = base + DW'(i);
      end else begin
        bus.i_freq0_fdata = $urandom;
        bus.i_freq1_fdata = $urandom;
      end
      if (ex)
        oq.push_back('{cyc + 9, base + DW'(i), ff && i == 0});
      step();
    end
    bus.i_freq_ffram  = 1'b0;
    bus.i_freq0_fdata = '0;
    bus.i_freq1_fdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.i_freq_ffram  = 1'b0;
    bus.i_freq0_fdata = '0;
    bus.i_freq1_fdata = '0;
    step();
    do_reset();
    idle(100);

    for (int s = 0; s < 16; s++)
      slot(s % 8 == 0, 8, 32'h1000_0000 + DW'(s * 8), 1'b1);
    idle(9);
    do_reset();

    slot(1'b1, 5, 32'h2000_0000, 1'b0);
    mark_misalign();
    slot(1'b1, 8, 32'h2100_0000, 1'b1);
    slot(1'b0, 8, 32'h2200_0000, 1'b1);
    slot(1'b0, 5, 32'h2300_0000, 1'b0);
    mark_misalign();
    slot(1'b1, 8, 32'h2400_0000, 1'b1);
    slot(1'b0, 8, 32'h2500_0000, 1'b1);

    slot(1'b0, 5, 32'h3000_0000, 1'b0);
    do_reset();
    idle(20);
    slot(1'b1, 8, 32'h3100_0000, 1'b1);
    slot(1'b0, 8, 32'h3200_0000, 1'b1);
    idle(9);
    do_reset();

    slot(1'b1, 3, 32'h4000_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      mark_misalign();
      slot(1'b1, 3, 32'h4100_0000, 1'b0);
    end
    do_reset();
    idle(5);

    checks++;
    if (oq.size() != 0) begin
      errors++;
      $display("FAIL out_left got=%0d want=0", oq.size());
    end
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL err_left got=%0d want=0", eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
